// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
// State encoding and counter-width derivation used by serial_subtractor_ctrl.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH-1; keep at least one bit so WIDTH=1 still builds.
  function automatic int cnt_w(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/fs_cell.sv
// Combinational 1-bit full subtractor: d = a - b - borrow_in.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic d,
  output logic borrow_out
);

  assign d          = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (a - b), LSB first through one fs_cell.
// Define SERIAL_SUB_SAT_EN to clamp diff to zero on underflow.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one bit per cycle through the shared cell
// DONE  | one-cycle done pulse, result valid
module serial_subtractor_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, diff_r, diff_nxt;
  logic             bin, borrow_r;
  logic             cell_d, cell_bout;
  logic             last_bit, accept, run_en;

  fs_cell u_fs_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (bin),
    .d          (cell_d),
    .borrow_out (cell_bout)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  // New bit enters at the MSB; after WIDTH shifts bit 0 lands at diff[0].
  assign diff_nxt = WIDTH'({cell_d, diff_r} >> 1);

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    run_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        run_en = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      bin      <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
    end else if (accept) begin
      cnt      <= '0;
      a_sr     <= a;
      b_sr     <= b;
      bin      <= 1'b0;
      diff_r   <= '0;
      borrow_r <= 1'b0;
    end else if (run_en) begin
      cnt  <= cnt + 1'b1;
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      bin  <= cell_bout;
`ifdef SERIAL_SUB_SAT_EN
      if (last_bit && cell_bout) diff_r <= '0;
      else                       diff_r <= diff_nxt;
`else
      diff_r <= diff_nxt;
`endif
      if (last_bit) borrow_r <= cell_bout;
    end
  end

  assign diff       = diff_r;
  assign borrow_out = borrow_r;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start8 = 1'b0, start1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy8, done8, bout8, busy1, done1, bout1;
  logic [7:0] diff8;
  logic [0:0] diff1;

  int nchecks = 0;
  int nerrors = 0;
  int lat, bc, t1, t2, ndone;
  logic [7:0] sat_exp;

  always #5 clk = ~clk;

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one WIDTH=8 op, then check latency, busy span and result.
  task automatic op8(input logic [7:0] av, input logic [7:0] bv,
                     input logic [7:0] ed, input logic eb, input string tag);
    @(negedge clk); a8 = av; b8 = bv; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0; a8 = ~av; b8 = ~bv;
    lat = 0; bc = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      if (busy8 === 1'b1) bc++;
      @(negedge clk); lat++;
    end
    if (busy8 === 1'b1) bc++;
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy_cycles"}, bc, 9);
    check({tag, "_diff"}, diff8, ed);
    check({tag, "_borrow"}, bout8, eb);
    @(negedge clk);
    check({tag, "_done_low_after"}, {busy8, done8}, 2'b00);
    check({tag, "_diff_held"}, diff8, ed);
  endtask

  task automatic op1(input logic av, input logic bv, input logic ed,
                     input logic eb, input string tag);
    @(negedge clk); a1 = av; b1 = bv; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    lat = 0;
    while (done1 !== 1'b1 && lat < 10) begin
      @(negedge clk); lat++;
    end
    check({tag, "_latency"}, lat, 1);
    check({tag, "_diff"}, diff1, ed);
    check({tag, "_borrow"}, bout1, eb);
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_busy", busy8, 0);
    check("reset_done", done8, 0);
    check("reset_diff", diff8, 0);
    check("reset_borrow", bout8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    op8(8'h5A, 8'h23, 8'h37, 1'b0, "sub_5a_23");

`ifdef SERIAL_SUB_SAT_EN
    sat_exp = 8'h00;
`else
    sat_exp = 8'hF0;
`endif
    op8(8'h10, 8'h20, sat_exp, 1'b1, "underflow_10_20");
    op8(8'hFF, 8'h00, 8'hFF, 1'b0, "sub_ff_00");
    op8(8'h00, 8'h01, (sat_exp == 8'h00) ? 8'h00 : 8'hFF, 1'b1, "underflow_00_01");

    // start with different operands while RUN/DONE must be ignored
    @(negedge clk); a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk); a8 = 8'h00; b8 = 8'hFF;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    check("ignore_start_latency", lat, 8);
    check("ignore_start_diff", diff8, 8'hFE);
    check("ignore_start_borrow", bout8, 0);
    @(negedge clk); start8 = 1'b0;
    ndone = 0; bc = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
      if (busy8 === 1'b1) bc++;
    end
    check("ignore_start_no_second_done", ndone, 0);
    check("ignore_start_no_second_busy", bc, 0);
    check("ignore_start_diff_held", diff8, 8'hFE);

    // asynchronous reset mid-RUN
    @(negedge clk); a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", busy8, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", busy8, 0);
    check("mid_reset_done", done8, 0);
    check("mid_reset_diff", diff8, 0);
    check("mid_reset_borrow", bout8, 0);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8 === 1'b1) ndone++;
    end
    check("reset_discards_op", ndone, 0);
    op8(8'h03, 8'h03, 8'h00, 1'b0, "after_reset_03_03");

    // back-to-back with start held high
    @(negedge clk); a8 = 8'h5A; b8 = 8'h23; start8 = 1'b1;
    @(negedge clk); a8 = 8'h10; b8 = 8'h01;
    lat = 0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk); lat++;
    end
    t1 = lat;
    check("b2b_first_latency", t1, 8);
    check("b2b_first_diff", diff8, 8'h37);
    check("b2b_first_borrow", bout8, 0);
    @(negedge clk); lat++;
    while (done8 !== 1'b1 && lat < 60) begin
      @(negedge clk); lat++;
    end
    t2 = lat;
    start8 = 1'b0;
    check("b2b_spacing", t2 - t1, 10);
    check("b2b_second_diff", diff8, 8'h0F);
    check("b2b_second_borrow", bout8, 0);
    repeat (12) @(negedge clk);
    check("b2b_stopped", busy8, 0);

    // WIDTH=1 truth table
    op1(1'b0, 1'b0, 1'b0, 1'b0, "w1_00");
    op1(1'b0, 1'b1, 1'b1, 1'b1, "w1_01");
    op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_10");
    op1(1'b1, 1'b1, 1'b0, 1'b0, "w1_11");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
